// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan receiver: segment patterns ([6]=a .. [0]=g),
// FSM state encoding and the blanking enable value.
package fnd_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  typedef enum logic {
    S_HUNT    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  localparam logic [5:0] ENB_BLANK = 6'b111111;

endpackage

// File: rtl/fnd_scan_rx_seg_to_num.sv
// Seven-segment pattern to number decoder (inverse of the display decoder).
// Macro FND_SCAN_RX_HEX_DECODE_EN adds the A..F patterns.
module seg_to_num
  import fnd_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] num,
  output logic       err
);

  always_comb begin
    num = 4'hF;
    err = 1'b0;
    case (seg)
      SEG_0: num = 4'd0;
      SEG_1: num = 4'd1;
      SEG_2: num = 4'd2;
      SEG_3: num = 4'd3;
      SEG_4: num = 4'd4;
      SEG_5: num = 4'd5;
      SEG_6: num = 4'd6;
      SEG_7: num = 4'd7;
      SEG_8: num = 4'd8;
      SEG_9: num = 4'd9;
`ifdef FND_SCAN_RX_HEX_DECODE_EN
      SEG_A: num = 4'd10;
      SEG_B: num = 4'd11;
      SEG_C: num = 4'd12;
      SEG_D: num = 4'd13;
      SEG_E: num = 4'd14;
      SEG_F: num = 4'd15;
`endif
      default: begin
        num = 4'hF;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fnd_scan_rx.sv
// Receiver for the multiplexed 6-digit FND scan bus: rebuilds frame, dots and decoded digits.
// Optional macro FND_SCAN_RX_HEX_DECODE_EN enables A..F decoding in seg_to_num.
module fnd_scan_rx
  import fnd_pkg::*;
#(
  parameter int          STABLE_CYC  = 4,
  parameter logic [31:0] TIMEOUT_CYC = 32'd200000,
  parameter int          NUM_DIGITS  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  i_seg,
  input  logic        i_seg_dp,
  input  logic [5:0]  i_seg_enb,
  output logic [41:0] o_six_digit_seg,
  output logic [5:0]  o_six_dp,
  output logic [23:0] o_digits,
  output logic [5:0]  o_digit_err,
  output logic        o_frame_valid,
  output logic        o_order_err,
  output logic        o_enb_err,
  output logic        o_stall
);

  localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYC - 1);
  localparam logic [2:0] LAST_IDX  = 3'(NUM_DIGITS - 1);

  logic [6:0] seg_p0, seg_p1;
  logic       dp_p0, dp_p1;
  logic [5:0] enb_p0, enb_p1, enb_prev;
  logic [7:0] stab_cnt, stab_nxt;
  logic       settled, enb_onehot, enb_blank, acc, enb_bad, timeout_hit;
  logic [2:0] acc_idx, exp_idx;
  logic [31:0] tcnt;
  state_t     state;
  logic       done;
  logic [6:0] sh_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] sh_dp;
  logic [4*NUM_DIGITS-1:0] dec_num;
  logic [NUM_DIGITS-1:0]   dec_err;

  // stage p0/p1: two-flop synchronizer on all bus lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_p0 <= '0;
      seg_p1 <= '0;
      dp_p0  <= 1'b0;
      dp_p1  <= 1'b0;
      enb_p0 <= ENB_BLANK;
      enb_p1 <= ENB_BLANK;
    end else begin
      seg_p0 <= i_seg;
      seg_p1 <= seg_p0;
      dp_p0  <= i_seg_dp;
      dp_p1  <= dp_p0;
      enb_p0 <= i_seg_enb;
      enb_p1 <= enb_p0;
    end
  end

  // Settle count includes the sample where the enable changed, so the match
  // against STABLE_CYC-1 happens once per dwell; saturation prevents a re-hit.
  always_comb begin
    if (enb_p1 != enb_prev)
      stab_nxt = 8'd0;
    else if (stab_cnt == 8'hFF)
      stab_nxt = stab_cnt;
    else
      stab_nxt = stab_cnt + 8'd1;
    settled    = (stab_nxt == STABLE_M1);
    enb_onehot = $onehot(~enb_p1);
    enb_blank  = (enb_p1 == ENB_BLANK);
    acc        = settled && enb_onehot;
    enb_bad    = settled && !enb_onehot && !enb_blank;
    timeout_hit = !acc && (tcnt == TIMEOUT_CYC - 32'd1);
    acc_idx = 3'd0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (!enb_p1[k]) acc_idx = 3'(k);
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg_to_num u_dec (
      .seg (sh_seg[g]),
      .num (dec_num[4*g +: 4]),
      .err (dec_err[g])
    );
  end

  // stage p2: settle/timeout counters, frame-assembly FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enb_prev        <= ENB_BLANK;
      stab_cnt        <= '0;
      tcnt            <= '0;
      state           <= S_HUNT;
      exp_idx         <= '0;
      done            <= 1'b0;
      sh_dp           <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) sh_seg[k] <= '0;
      o_six_digit_seg <= '0;
      o_six_dp        <= '0;
      o_digits        <= '0;
      o_digit_err     <= '1;
      o_frame_valid   <= 1'b0;
      o_order_err     <= 1'b0;
      o_enb_err       <= 1'b0;
      o_stall         <= 1'b0;
    end else begin
      enb_prev      <= enb_p1;
      stab_cnt      <= stab_nxt;
      o_frame_valid <= 1'b0;
      o_order_err   <= 1'b0;
      if (enb_bad) o_enb_err <= 1'b1;

      if (acc) begin
        tcnt    <= '0;
        o_stall <= 1'b0;
      end else if (tcnt != TIMEOUT_CYC) begin
        tcnt <= tcnt + 32'd1;
      end
      if (timeout_hit) o_stall <= 1'b1;

      if (done) begin
        done          <= 1'b0;
        o_frame_valid <= 1'b1;
        o_six_dp      <= sh_dp;
        o_digits      <= dec_num;
        o_digit_err   <= dec_err;
        for (int k = 0; k < NUM_DIGITS; k++) o_six_digit_seg[7*k +: 7] <= sh_seg[k];
      end

      if (timeout_hit) begin
        state   <= S_HUNT;
        exp_idx <= '0;
      end else if (acc) begin
        case (state)
          S_HUNT: begin
            if (acc_idx == 3'd0) begin
              sh_seg[0] <= seg_p1;
              sh_dp[0]  <= dp_p1;
              exp_idx   <= 3'd1;
              state     <= S_COLLECT;
            end
          end
          S_COLLECT: begin
            if (acc_idx == exp_idx) begin
              sh_seg[acc_idx] <= seg_p1;
              sh_dp[acc_idx]  <= dp_p1;
              if (acc_idx == LAST_IDX) begin
                done    <= 1'b1;
                exp_idx <= 3'd0;
              end else begin
                exp_idx <= exp_idx + 3'd1;
              end
            end else begin
              o_order_err <= 1'b1;
              sh_dp       <= '0;
              for (int k = 0; k < NUM_DIGITS; k++) sh_seg[k] <= '0;
              if (acc_idx == 3'd0) begin
                sh_seg[0] <= seg_p1;
                sh_dp[0]  <= dp_p1;
                exp_idx   <= 3'd1;
              end else begin
                exp_idx <= 3'd0;
                state   <= S_HUNT;
              end
            end
          end
          default: state <= S_HUNT;
        endcase
      end
    end
  end

endmodule
